// File: rtl/vcco_seq_pkg.sv
// Shared types for the VCCO break-before-make sequencer.
package vcco_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BREAK = 3'd1,
        MAKE  = 3'd2,
        RUN   = 3'd3,
        FAULT = 3'd4
    } vseq_state_t;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sync_debounce.sv
// 2-FF synchronizer followed by a stability filter; depth 1 bypasses the filter
// so the synchronized level is used directly.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 1) begin : g_bypass
            assign dout = s2_q;
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             out_q;
            logic             out_d;

            // Any sample that agrees with the current output restarts the run.
            always_comb begin
                cnt_d = '0;
                out_d = out_q;
                if (s2_q != out_q) begin
                    if (cnt_q == LAST) begin
                        out_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    out_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    out_q <= out_d;
                end
            end

            assign dout = out_q;
        end
    endgenerate

endmodule

// File: rtl/vcco_switch_seq.sv
// Break-before-make sequencer for the VCCO gate pair and output relay.
// Outputs are registered from the next state so they move with the state register.
module vcco_switch_seq
    import vcco_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int DEAD_CYCLES     = 4,
    parameter int SETTLE_CYCLES   = 8,
    parameter int RETRY_CYCLES    = 1024,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vcco_is_high,
    input  logic        input_ok,
    input  logic        vout_req,
    output logic        vcco_hi_en,
    output logic        vcco_lo_en,
    output logic        vout_relay_en,
    output logic        busy,
    output logic        fault,
    output vseq_state_t state_dbg
);

    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST  = CNT_W'(RETRY_CYCLES - 1);

    logic sel;
    logic ok_s;

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sel_sync (
        .clk(clk), .rst_n(rst_n), .din(vcco_is_high), .dout(sel)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(CNT_W)) u_ok_sync (
        .clk(clk), .rst_n(rst_n), .din(input_ok), .dout(ok_s)
    );

    vseq_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             target_q, target_d;
    logic             hi_q, hi_d, lo_q, lo_d, relay_q, relay_d;
    logic             busy_q, busy_d, fault_q, fault_d;
    logic             gate_on;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        if (!ok_s) begin
            state_d = FAULT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vout_req) begin
                        state_d  = BREAK;
                        target_d = sel;
                        cnt_d    = '0;
                    end
                end
                BREAK: begin
                    if (sel != target_q) begin
                        target_d = sel;
                        cnt_d    = '0;
                    end else if (cnt_q == DEAD_LAST) begin
                        state_d = MAKE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MAKE: begin
                    if (sel != target_q) begin
                        state_d  = BREAK;
                        target_d = sel;
                        cnt_d    = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    // A dropped request wins over a simultaneous rail change.
                    if (!vout_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (sel != target_q) begin
                        state_d  = BREAK;
                        target_d = sel;
                        cnt_d    = '0;
                    end
                end
                FAULT: begin
                    if (cnt_q == RETRY_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        gate_on = (state_d == MAKE) || (state_d == RUN);
        hi_d    = gate_on && target_d;
        lo_d    = gate_on && !target_d;
        relay_d = (state_d == RUN);
        busy_d  = (state_d == BREAK) || (state_d == MAKE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= 1'b0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
            relay_q  <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            relay_q  <= relay_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

    assign vcco_hi_en    = hi_q;
    assign vcco_lo_en    = lo_q;
    assign vout_relay_en = relay_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_vcco_switch_seq.sv
// Directed bench for vcco_switch_seq with a background gate-exclusivity and
// dead-time monitor, finishing with a short random soak.
module tb_vcco_switch_seq;
  import vcco_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vcco_is_high;
  logic        input_ok;
  logic        vout_req;
  logic        vcco_hi_en;
  logic        vcco_lo_en;
  logic        vout_relay_en;
  logic        busy;
  logic        fault;
  vseq_state_t state_dbg;

  int errors = 0;
  int checks = 0;

  // {hi, lo, relay, busy, fault}
  logic [4:0] o;
  assign o = {vcco_hi_en, vcco_lo_en, vout_relay_en, busy, fault};

  always #5 clk = ~clk;

  vcco_switch_seq #(
    .DEBOUNCE_CYCLES(3),
    .DEAD_CYCLES(4),
    .SETTLE_CYCLES(8),
    .RETRY_CYCLES(16),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vcco_is_high(vcco_is_high),
    .input_ok(input_ok),
    .vout_req(vout_req),
    .vcco_hi_en(vcco_hi_en),
    .vcco_lo_en(vcco_lo_en),
    .vout_relay_en(vout_relay_en),
    .busy(busy),
    .fault(fault),
    .state_dbg(state_dbg)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [4:0] exp);
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: outs(hi,lo,relay,busy,fault) observed=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic check_state(input string tag, input vseq_state_t exp);
    checks++;
    assert (state_dbg === exp) else begin
      errors++;
      $error("FAIL %s: state observed=%0d expected=%0d", tag, state_dbg, exp);
    end
  endtask

  // Background monitor: exclusivity, dead time on crossover, settle before relay.
  int   low_cnt   = 0;
  int   on_cnt    = 0;
  int   last_gate = 0;
  int   prev_gate = 0;
  logic relay_prev = 1'b0;
  always @(negedge clk) begin
    int cur;
    checks++;
    assert (!(vcco_hi_en && vcco_lo_en)) else begin
      errors++;
      $error("FAIL excl: hi=%b lo=%b expected not both 1", vcco_hi_en, vcco_lo_en);
    end
    cur = vcco_hi_en ? 2 : (vcco_lo_en ? 1 : 0);
    if (vout_relay_en && !relay_prev) begin
      checks++;
      assert (on_cnt >= 8) else begin
        errors++;
        $error("FAIL settle: gate-on cycles before relay observed=%0d expected>=8", on_cnt);
      end
    end
    if (cur != 0) begin
      if (last_gate != 0 && cur != last_gate) begin
        checks++;
        assert (low_cnt >= 4) else begin
          errors++;
          $error("FAIL dead_time: low cycles observed=%0d expected>=4", low_cnt);
        end
      end
      on_cnt    = (cur == prev_gate) ? on_cnt + 1 : 1;
      low_cnt   = 0;
      last_gate = cur;
    end else begin
      on_cnt  = 0;
      low_cnt = low_cnt + 1;
    end
    prev_gate  = cur;
    relay_prev = vout_relay_en;
  end

  initial begin
    rst_n        = 1'b0;
    input_ok     = 1'b1;
    vcco_is_high = 1'b0;
    vout_req     = 1'b0;

    // Reset, then power-up hold-off while ok_s leaves its reset value of 0
    step(2);
    check("reset_outs", 5'b00000);
    rst_n = 1'b1;
    step(1);
    check("powerup_fault", 5'b00001);
    step(16);
    check("powerup_fault_hold", 5'b00001);
    step(1);
    check("powerup_idle", 5'b00000);
    check_state("powerup_idle_state", IDLE);

    // Connect on low rail
    vout_req = 1'b1;
    step(1);
    check("conn_break", 5'b00010);
    step(3);
    check("conn_break_end", 5'b00010);
    step(1);
    check("conn_lo_rise", 5'b01010);
    step(7);
    check("conn_make_end", 5'b01010);
    step(1);
    check("conn_relay", 5'b01100);
    check_state("conn_run_state", RUN);

    // Rail switch in RUN
    vcco_is_high = 1'b1;
    step(5);
    check("sw_before_break", 5'b01100);
    step(1);
    check("sw_break", 5'b00010);
    step(3);
    check("sw_dead_end", 5'b00010);
    step(1);
    check("sw_hi_rise", 5'b10010);
    step(7);
    check("sw_make_end", 5'b10010);
    step(1);
    check("sw_relay", 5'b10100);

    // Two-cycle comparator glitch in RUN is filtered
    vcco_is_high = 1'b0;
    step(2);
    vcco_is_high = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("glitch_run", 5'b10100);
    end

    // Disconnect
    vout_req = 1'b0;
    step(1);
    check("disconnect", 5'b00000);
    check_state("disconnect_state", IDLE);

    // One-cycle toggle during BREAK does not disturb the dead time
    vout_req = 1'b1;
    step(1);
    check("gb_break", 5'b00010);
    vcco_is_high = 1'b0;
    step(1);
    vcco_is_high = 1'b1;
    step(2);
    check("gb_break_end", 5'b00010);
    step(1);
    check("gb_make", 5'b10010);

    // Fault in MAKE, hold 50 cycles, retry, reconnect
    input_ok = 1'b0;
    step(2);
    check("flt_sync", 5'b10010);
    step(1);
    check("flt_enter", 5'b00001);
    step(47);
    check("flt_hold", 5'b00001);
    input_ok = 1'b1;
    step(17);
    check("flt_retry_end", 5'b00001);
    step(1);
    check("flt_idle", 5'b00000);
    check_state("flt_idle_state", IDLE);
    step(1);
    check("flt_reconnect", 5'b00010);
    step(4);
    check("flt_make", 5'b10010);
    check_state("flt_make_state", MAKE);

    // Asynchronous reset during MAKE
    rst_n = 1'b0;
    #1;
    check("rst_async", 5'b00000);
    step(2);
    rst_n = 1'b1;
    step(1);
    check("rst_fault", 5'b00001);
    step(16);
    check("rst_fault_hold", 5'b00001);
    step(1);
    check("rst_idle", 5'b00000);
    step(1);
    check("rst_break", 5'b00010);
    step(3);
    check("rst_break_end", 5'b00010);
    step(1);
    check("rst_make", 5'b10010);
    step(7);
    check("rst_make_end", 5'b10010);
    step(1);
    check("rst_run", 5'b10100);

    // Rail change during MAKE returns to BREAK
    vcco_is_high = 1'b0;
    step(5);
    check("mk_run_hold", 5'b10100);
    step(1);
    check("mk_break", 5'b00010);
    step(4);
    check("mk_lo_make", 5'b01010);
    vcco_is_high = 1'b1;
    step(5);
    check("mk_make_hold", 5'b01010);
    step(1);
    check("mk_rebreak", 5'b00010);
    step(3);
    check("mk_rebreak_end", 5'b00010);
    step(1);
    check("mk_hi_make", 5'b10010);

    // Random soak; the background monitor does the checking
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) vcco_is_high = ~vcco_is_high;
      if ($urandom_range(0, 99) == 0) vout_req = ~vout_req;
      if (input_ok ? ($urandom_range(0, 249) == 0) : ($urandom_range(0, 9) == 0))
        input_ok = ~input_ok;
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
